hash32_check: RTL
=================

Name: hash32_check

Overview:
Receive-side checker for the 32-bit stream hash. It consumes a counted stream of 32-bit words over a valid/ready handshake and folds each accepted word into a running hash. At end of stream it compares the result against an expected value and reports pass/fail. It is the verifying end for stream hashes generated upstream, for example by linked-list walkers.

Parameters:
INITIAL_VALUE, 32'h000014D6, hash seed loaded at start.
COUNT_W, 16, width of word count and words_seen.

Ports:
clk  input  1  clock; all logic on posedge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  pulse; honoured only in IDLE or DONE; captures num_words and expected_hash.
num_words  input  COUNT_W  number of words to hash.
expected_hash  input  32  reference hash.
in_valid  input  1  stream word valid.
in_data  input  32  stream word.
in_last  input  1  producer end-of-stream marker, qualified by in_valid.
in_ready  output  1  checker accepts a word this cycle.
busy  output  1  state is RUN or CMP.
done  output  1  high in DONE; result valid.
pass  output  1  hash matched and no length error; valid while done.
len_err  output  1  in_last disagreed with num_words; valid while done.
hash_value  output  32  running/final hash.
words_seen  output  COUNT_W  words accepted since start.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=0, busy=0, done=0, pass=0, len_err=0; hash_value=INITIAL_VALUE; words_seen=0.
- Hash update per accepted word d, applied to current value v:
  - v'[31] = d[31]^v[0]
  - v'[i] = d[i]^v[i+1] for i=30..0
  - bits 6,4,2,1,0 are additionally XORed with v[0].
  - Equivalent form: v' = {v[0], v[31:1]} ^ d ^ (v[0] ? 32'h57 : 0).
- States: IDLE, RUN, CMP, DONE.
- IDLE/DONE + start:
  - hash_value<=INITIAL_VALUE, words_seen<=0, len_err<=0, done<=0, pass<=0.
  - Capture num_words and expected_hash.
  - Next state RUN, or CMP if num_words==0.
- RUN:
  - in_ready=1 combinationally.
  - A word is accepted when in_valid&&in_ready; the hash updates and words_seen increments on that edge.
  - On the word where words_seen+1==num_words, go to CMP.
  - in_last on any earlier word sets len_err. Remaining words are still consumed up to num_words.
  - in_last low on the final word also sets len_err.
  - in_valid low: hold state, no update.
- CMP, one cycle, in_ready=0:
  - pass<=(hash_value==exp_q)&&!len_err.
  - done<=1.
  - Next state DONE.
- DONE:
  - Results held, in_ready=0, stream ignored.
  - start in the same cycle is accepted and restarts the run.
- start while in RUN/CMP is ignored; no abort.
- Latency: done rises 2 edges after the final accepted word (RUN->CMP edge, then CMP->DONE edge). With num_words==0, done rises 2 edges after start.
- Throughput: one word per cycle in RUN.
- words_seen stops at num_words; no wrap occurs because num_words is at most 2^COUNT_W-1.
- reset_n asserted mid-run: immediate return to reset values; partial hash discarded.

Test Plan:
- Reset, then start num_words=1, expected=32'h00000A6B, one word in_data=0 with in_last=1 -> hash_value=32'h00000A6B, done=1 after 2 edges, pass=1, len_err=0.
- num_words=2, two words 0, last on second, expected=32'h80000562 -> pass=1. Repeat with expected=32'h80000563 -> pass=0, done=1.
- One word 32'hFFFFFFFF, expected=32'hFFFFF594 -> pass=1. Insert 3 idle cycles (in_valid=0) first -> same result, words_seen=1.
- num_words=3, in_last on word 2 -> 3 words consumed, len_err=1, pass=0 even with correct hash. Second case: in_last=0 on word 3 -> len_err=1.
- num_words=0, expected=32'h000014D6 -> in_ready never high, pass=1 after 2 edges. start during RUN -> ignored, words_seen keeps counting.
- Deassert reset_n after 1 of 4 words -> outputs return to reset values immediately. New start then runs normally. Back-to-back start in DONE -> new run begins, done clears next edge.

Source files
------------

// File: rtl/hash32_check.sv
// Receive-side checker for the 32-bit stream hash: folds a counted word stream
// into a running hash and compares it against a reference at end of stream.
module hash32_check #(
    parameter logic [31:0] INITIAL_VALUE = 32'h000014D6,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_words,
    input  logic [31:0]        expected_hash,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               len_err,
    output logic [31:0]        hash_value,
    output logic [COUNT_W-1:0] words_seen
);

    typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

    state_t             state;
    logic [COUNT_W-1:0] num_q;
    logic [31:0]        exp_q;
    logic [31:0]        hash_next;
    logic [COUNT_W-1:0] seen_next;
    logic               accept;
    logic               final_word;

    // Shift right with feedback of the dropped bit into bit 31 and taps 6,4,2,1,0.
    always_comb begin
        hash_next = {hash_value[0], hash_value[31:1]} ^ in_data
                  ^ (hash_value[0] ? 32'h0000_0057 : '0);
    end

    assign seen_next  = words_seen + COUNT_W'(1);
    assign final_word = (seen_next == num_q);
    assign in_ready   = (state == RUN);
    assign busy       = (state == RUN) || (state == CMP);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            num_q      <= '0;
            exp_q      <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            len_err    <= 1'b0;
            hash_value <= INITIAL_VALUE;
            words_seen <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        hash_value <= INITIAL_VALUE;
                        words_seen <= '0;
                        len_err    <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        num_q      <= num_words;
                        exp_q      <= expected_hash;
                        state      <= (num_words == '0) ? CMP : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        hash_value <= hash_next;
                        words_seen <= seen_next;
                        // in_last must coincide exactly with the counted final word.
                        if (final_word) begin
                            state <= CMP;
                            if (!in_last) len_err <= 1'b1;
                        end else if (in_last) begin
                            len_err <= 1'b1;
                        end
                    end
                end
                CMP: begin
                    pass  <= (hash_value == exp_q) && !len_err;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
